// File: rtl/lap_split_ctrl_if.sv
// Stopwatch-to-display bus for the lap/split sequencer.
// master = stopwatch/run-control side, slave = lap_split_ctrl.
interface lap_split_ctrl_if #(
  parameter int unsigned TIME_W = 16,
  parameter int unsigned PTR_W  = 2
);
  logic              running;
  logic              lap_btn;
  logic              recall_btn;
  logic              clear_pulse;
  logic [TIME_W-1:0] time_in;
  logic [TIME_W-1:0] disp_time;
  logic              disp_sel;
  logic [PTR_W-1:0]  lap_idx;
  logic [PTR_W:0]    lap_count;
  logic              full;

  modport master (
    output running, lap_btn, recall_btn, clear_pulse, time_in,
    input  disp_time, disp_sel, lap_idx, lap_count, full
  );

  modport slave (
    input  running, lap_btn, recall_btn, clear_pulse, time_in,
    output disp_time, disp_sel, lap_idx, lap_count, full
  );
endinterface

// File: rtl/lap_split_ctrl.sv
// Lap/split sequencer: captures lap snapshots, holds each split on the
// display, and steps through stored laps while the stopwatch is stopped.
module lap_split_ctrl #(
  parameter int unsigned TIME_W      = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PTR_W       = 2,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input logic             clk,
  input logic             rst,
  lap_split_ctrl_if.slave bus
);

  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {LIVE, SPLIT, RECALL} state_t;

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   disp_q, disp_d;
  logic                sel_q;
  logic [PTR_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                wr_en;
  logic [TIME_W-1:0]   lap_mem [DEPTH];

  logic is_full, lap_take, capture, recall_more;

  assign is_full     = (cnt_q == CNT_W'(DEPTH));
  assign lap_take    = bus.lap_btn & bus.running;
  assign capture     = !bus.clear_pulse && lap_take && (state_q != RECALL);
  assign recall_more = ((CNT_W'(idx_q) + CNT_W'(1)) < cnt_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LIVE;
    else      state_q <= state_d;
  end

  // Next state: clear > running-based exit > lap > recall
  always_comb begin
    state_d = state_q;
    if (bus.clear_pulse) begin
      state_d = LIVE;
    end else begin
      case (state_q)
        LIVE: begin
          if (lap_take)
            state_d = SPLIT;
          else if (bus.recall_btn && !bus.running && (cnt_q != '0))
            state_d = RECALL;
        end
        SPLIT: begin
          if (!bus.running)        state_d = LIVE;
          else if (lap_take)       state_d = SPLIT;
          else if (hold_q == '0)   state_d = LIVE;
        end
        RECALL: begin
          if (bus.running)                         state_d = LIVE;
          else if (bus.recall_btn && !recall_more) state_d = LIVE;
        end
        default: state_d = LIVE;
      endcase
    end
  end

  // Datapath next values; the display source follows the next state so
  // the shown word lines up with disp_sel.
  always_comb begin
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    hold_d   = hold_q;
    wr_en    = 1'b0;
    if (bus.clear_pulse) begin
      idx_d    = '0;
      cnt_d    = '0;
      wr_ptr_d = '0;
      hold_d   = '0;
    end else begin
      if (capture) begin
        hold_d = HOLD_W'(HOLD_CYCLES - 1);
        if (!is_full) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end else if (state_d == SPLIT) begin
        hold_d = hold_q - HOLD_W'(1);
      end else begin
        hold_d = '0;
      end
      if (state_d != RECALL)
        idx_d = '0;
      else if (state_q == RECALL && bus.recall_btn)
        idx_d = idx_q + PTR_W'(1);
    end

    case (state_d)
      SPLIT:   disp_d = capture ? bus.time_in : disp_q;
      RECALL:  disp_d = lap_mem[idx_d];
      default: disp_d = bus.time_in;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_q   <= '0;
      sel_q    <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      disp_q   <= disp_d;
      sel_q    <= (state_d != LIVE);
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  // Lap storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_en) lap_mem[wr_ptr_q] <= bus.time_in;
  end

  assign bus.disp_time = disp_q;
  assign bus.disp_sel  = sel_q;
  assign bus.lap_idx   = idx_q;
  assign bus.lap_count = cnt_q;
  assign bus.full      = is_full;

endmodule

// File: tb/tb_lap_split_ctrl.sv
// Directed scoreboard bench for lap_split_ctrl with a short hold time.
module tb_lap_split_ctrl;
  localparam int unsigned TW = 16;
  localparam int unsigned PW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lap_split_ctrl_if #(.TIME_W(TW), .PTR_W(PW)) bus ();

  lap_split_ctrl #(.TIME_W(TW), .DEPTH(4), .PTR_W(PW), .HOLD_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] disp;
    logic        sel;
    logic [1:0]  idx;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".disp_time"}, 32'(bus.disp_time), 32'(e.disp));
      chk({e.tag, ".disp_sel"},  32'(bus.disp_sel),  32'(e.sel));
      chk({e.tag, ".lap_idx"},   32'(bus.lap_idx),   32'(e.idx));
      chk({e.tag, ".lap_count"}, 32'(bus.lap_count), 32'(e.cnt));
      chk({e.tag, ".full"},      32'(bus.full),      32'(e.cnt == 3'd4));
    end
  endtask

  // Push the expected post-edge outputs for the inputs just driven, then clock.
  task automatic step(input string tag, input logic [15:0] disp, input logic sel,
                      input logic [1:0] idx, input logic [2:0] cnt);
    exp_t e;
    e.tag = tag; e.disp = disp; e.sel = sel; e.idx = idx; e.cnt = cnt;
    sb.push_back(e);
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".disp_time"}, 32'(bus.disp_time), 32'h0);
    chk({tag, ".disp_sel"},  32'(bus.disp_sel),  32'h0);
    chk({tag, ".lap_idx"},   32'(bus.lap_idx),   32'h0);
    chk({tag, ".lap_count"}, 32'(bus.lap_count), 32'h0);
    chk({tag, ".full"},      32'(bus.full),      32'h0);
  endtask

  initial begin
    logic [15:0] t;
    bus.running = 1'b0; bus.lap_btn = 1'b0; bus.recall_btn = 1'b0;
    bus.clear_pulse = 1'b0; bus.time_in = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;

    bus.time_in = 16'h1111; step("live0", 16'h1111, 1'b0, 2'd0, 3'd0);
    bus.time_in = 16'h1112; step("live1", 16'h1112, 1'b0, 2'd0, 3'd0);

    // Split hold
    bus.running = 1'b1; bus.time_in = 16'h0123; bus.lap_btn = 1'b1;
    step("cap", 16'h0123, 1'b1, 2'd0, 3'd1);
    bus.lap_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.time_in = 16'(16'h0200 + i);
      step("hold", 16'h0123, 1'b1, 2'd0, 3'd1);
    end
    bus.time_in = 16'h0203; step("release", 16'h0203, 1'b0, 2'd0, 3'd1);
    bus.time_in = 16'h0204; step("live_after", 16'h0204, 1'b0, 2'd0, 3'd1);

    // Asynchronous reset mid-split
    bus.time_in = 16'h0300; bus.lap_btn = 1'b1;
    step("cap_b", 16'h0300, 1'b1, 2'd0, 3'd2);
    bus.lap_btn = 1'b0;
    #3 rst = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    bus.time_in = 16'h0400; step("post_rst", 16'h0400, 1'b0, 2'd0, 3'd0);

    // Fill and saturate
    for (int i = 0; i < 5; i++) begin
      t = 16'(16'h0010 * (i + 1));
      bus.time_in = t; bus.lap_btn = 1'b1;
      step("fill_cap", t, 1'b1, 2'd0, 3'((i < 4) ? i + 1 : 4));
      bus.lap_btn = 1'b0; bus.time_in = 16'h0AAA;
      step("fill_gap", t, 1'b1, 2'd0, 3'((i < 4) ? i + 1 : 4));
    end
    bus.running = 1'b0; bus.time_in = 16'h0060;
    step("run_drop", 16'h0060, 1'b0, 2'd0, 3'd4);
    bus.lap_btn = 1'b1; bus.time_in = 16'h0061;
    step("lap_stopped", 16'h0061, 1'b0, 2'd0, 3'd4);
    bus.lap_btn = 1'b0;

    // Recall through all stored laps
    bus.time_in = 16'h0777;
    for (int i = 0; i < 4; i++) begin
      t = 16'(16'h0010 * (i + 1));
      bus.recall_btn = 1'b1; step("rc", t, 1'b1, 2'(i), 3'd4);
      bus.recall_btn = 1'b0; step("rc_hold", t, 1'b1, 2'(i), 3'd4);
    end
    bus.recall_btn = 1'b1; step("rc_exit", 16'h0777, 1'b0, 2'd0, 3'd4);

    // Running rises mid-recall
    step("rc2_0", 16'h0010, 1'b1, 2'd0, 3'd4);
    step("rc2_1", 16'h0020, 1'b1, 2'd1, 3'd4);
    bus.recall_btn = 1'b0; bus.running = 1'b1; bus.time_in = 16'h0888;
    step("run_exit", 16'h0888, 1'b0, 2'd0, 3'd4);

    // Clear with three laps stored
    bus.running = 1'b0; bus.clear_pulse = 1'b1;
    step("clr0", 16'h0888, 1'b0, 2'd0, 3'd0);
    bus.clear_pulse = 1'b0; bus.running = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = 16'(16'h0100 * (i + 1));
      bus.time_in = t; bus.lap_btn = 1'b1;
      step("re_cap", t, 1'b1, 2'd0, 3'(i + 1));
    end
    bus.lap_btn = 1'b0; bus.running = 1'b0; bus.time_in = 16'h0999;
    step("stop3", 16'h0999, 1'b0, 2'd0, 3'd3);
    bus.recall_btn = 1'b1; step("rc3", 16'h0100, 1'b1, 2'd0, 3'd3);
    bus.recall_btn = 1'b0; bus.clear_pulse = 1'b1;
    step("clr3", 16'h0999, 1'b0, 2'd0, 3'd0);
    bus.clear_pulse = 1'b0; bus.recall_btn = 1'b1;
    step("rc_empty", 16'h0999, 1'b0, 2'd0, 3'd0);
    bus.recall_btn = 1'b0;

    // Simultaneous events
    bus.running = 1'b1; bus.time_in = 16'h0555; bus.lap_btn = 1'b1; bus.clear_pulse = 1'b1;
    step("lap_clr", 16'h0555, 1'b0, 2'd0, 3'd0);
    bus.clear_pulse = 1'b0;
    step("lap_after", 16'h0555, 1'b1, 2'd0, 3'd1);
    bus.running = 1'b0; bus.time_in = 16'h0666;
    step("lap_fall", 16'h0666, 1'b0, 2'd0, 3'd1);
    bus.lap_btn = 1'b0; bus.recall_btn = 1'b1;
    step("rc_last", 16'h0555, 1'b1, 2'd0, 3'd1);
    step("rc_last_exit", 16'h0666, 1'b0, 2'd0, 3'd1);
    bus.recall_btn = 1'b0;

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lap_split_ctrl.md
Name: lap_split_ctrl

Overview:
- Lap/split sequencer for the stopwatch display path.
- Sits between the stopwatch counter/run-control and the display driver.
- Captures lap snapshots of the running time into a small buffer and shows each new split on the display for a fixed hold time.
- While the stopwatch is stopped, lets the user step through stored laps, then returns the display to live time.

Parameters:
- TIME_W, 16, width of the packed BCD time word (MM:SS).
- DEPTH, 4, number of lap slots; must be a power of two.
- PTR_W, 2, log2(DEPTH).
- HOLD_CYCLES, 50000000, number of clocks a split stays frozen on the display (1 s at 50 MHz).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-low reset (asserted at 0).
- running, input, 1, run state from the stopwatch run controller.
- lap_btn, input, 1, one-cycle debounced pulse requesting a lap capture.
- recall_btn, input, 1, one-cycle debounced pulse that steps lap recall.
- clear_pulse, input, 1, clear request (only issued while stopped).
- time_in, input, TIME_W, live time from the counter.
- disp_time, output, TIME_W, registered time word to the display.
- disp_sel, output, 1, 0 = live time, 1 = lap/split shown.
- lap_idx, output, PTR_W, slot currently shown in recall.
- lap_count, output, PTR_W+1, number of valid laps (0..DEPTH).
- full, output, 1, high when lap_count == DEPTH.

Behaviour:
Reset (rst = 0, asynchronous):
- State is LIVE.
- disp_time = 0, disp_sel = 0, lap_idx = 0, lap_count = 0, full = 0.
- Write pointer = 0, hold counter = 0.
- Buffer contents are don't-care.

States: LIVE, SPLIT, RECALL.

Output rules:
- disp_time is registered, one cycle of latency from its source.
- LIVE: disp_time <= time_in.
- SPLIT: disp_time holds the captured word.
- RECALL: disp_time <= buf[lap_idx].
- disp_sel = 1 in SPLIT and RECALL, 0 in LIVE.
- full is combinational from lap_count.

LIVE:
- lap_btn & running, not full:
  - Write buf[wr_ptr] <= time_in; wr_ptr++ and lap_count++.
  - disp_time <= time_in (the same sample).
  - Load hold counter with HOLD_CYCLES-1; go to SPLIT.
- lap_btn & running & full:
  - No write; count and pointer unchanged.
  - The split is still displayed (disp_time <= time_in, go to SPLIT).
- recall_btn & !running & lap_count > 0: lap_idx <= 0; go to RECALL.
- recall_btn with lap_count == 0: ignored.
- lap_btn while !running: ignored.

SPLIT:
- Hold counter decrements each cycle; at 0, go to LIVE the next cycle.
- A new lap_btn & running recaptures under the same full rule and reloads the counter; it stays in SPLIT.
- running = 0: go to LIVE immediately (the next cycle shows live time).
- recall_btn: ignored.

RECALL:
- recall_btn:
  - If lap_idx < lap_count-1, lap_idx++.
  - Otherwise go to LIVE with lap_idx <= 0.
- running = 1: go to LIVE.
- lap_btn: ignored.

clear_pulse:
- Highest priority, in any state.
- lap_count <= 0, wr_ptr <= 0, lap_idx <= 0, state <= LIVE, hold counter <= 0.

Same-cycle priority:
- Order: clear_pulse > running-based exit > lap_btn > recall_btn.
- lap_btn and recall_btn together while running: the lap is taken and recall is ignored.

Wrap and width rules:
- Laps are never overwritten; capture saturates at DEPTH.
- wr_ptr wraps naturally but is never advanced when full.
- lap_count uses PTR_W+1 bits so it can represent DEPTH.

Test Plan:
- Scenario 1 (reset):
  - Stimulus: drive rst = 0 mid-SPLIT with disp_sel = 1.
  - Response: all outputs go to 0 asynchronously; after release the block is in LIVE and disp_time tracks time_in one cycle later.
- Scenario 2 (split hold):
  - Stimulus: HOLD_CYCLES = 4, running = 1, time_in = 16'h0123, one lap_btn pulse.
  - Response: next cycle disp_time = 0123, disp_sel = 1, lap_count = 1. disp_time stays 0123 for 4 cycles while time_in changes, then disp_sel = 0 and disp_time follows time_in.
- Scenario 3 (fill and saturate):
  - Stimulus: five lap_btn pulses at time_in = 0010, 0020, 0030, 0040, 0050.
  - Response: lap_count = 4 and full = 1 after the 4th pulse. The 5th pulse shows 0050 as a split, but lap_count stays 4 and buf[0..3] = 0010..0040.
- Scenario 4 (recall):
  - Stimulus: from Scenario 3, drop running, then five recall_btn pulses.
  - Response: disp_time shows 0010, 0020, 0030, 0040 with lap_idx = 0..3 and disp_sel = 1; the 5th pulse returns to LIVE with disp_sel = 0.
- Scenario 5 (exits and clear):
  - Stimulus: running rises mid-RECALL; separately, clear_pulse while stopped with lap_count = 3.
  - Response: LIVE the next cycle; after clear, lap_count = 0, full = 0, and recall_btn is ignored.
- Scenario 6 (simultaneous events):
  - Stimulus: lap_btn and clear_pulse in the same cycle; also lap_btn in the same cycle that running falls.
  - Response: clear wins (lap_count = 0, no write); with running falling the block goes to LIVE.
